// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the I/D block-RAM arbiter.
// Size codes, lane masks, FSM states and request bundle.
package bram_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    P_I = 1'b0,
    P_D = 1'b1
  } port_t;

  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    unique case (1'b1)
      (size == SZ_B): m = MASK_B;
      (size == SZ_H): m = MASK_H;
      default:        m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks bytes from {hi, lo} at the byte
// offset, truncates to the access size and extends to 32 bits.
module mem_load_align
  import bram_arbiter_pkg::*;
(
  input  logic [63:0] hilo,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] sh;

  always_comb begin
    sh = 32'(hilo >> {off, 3'b000});
    unique case (1'b1)
      (size == SZ_B): result = {{24{~uns & sh[7]}}, sh[7:0]};
      (size == SZ_H): result = {{16{~uns & sh[15]}}, sh[15:0]};
      default:        result = sh;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one byte-enabled sync RAM between fetch (I) and load/store (D),
// splitting misaligned D accesses into two aligned beats.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic              mem_wen,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  state_t            state_q, state_d;
  port_t             port_q, port_d;
  port_t             last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  req_t              req_q, req_d;
  logic [31:0]       lo_q, lo_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic              mwen_q, mwen_d;
  logic [31:0]       din_q, din_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;

  logic              gnt_i, gnt_d;
  logic [ADDR_W-1:0] nxt_addr, cur_addr;
  req_t              nxt_req, cur_req;
  logic [7:0]        lanes;
  logic [63:0]       steer;
  logic              split;
  logic [31:0]       ld_data;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    unique case (1'b1)
      (d_req && (!i_req || last_q == P_I)): gnt_d = 1'b1;
      (i_req && (!d_req || last_q == P_D)): gnt_i = 1'b1;
      default: ;
    endcase
    if (gnt_d) begin
      nxt_addr = d_addr;
      nxt_req  = '{wen: d_wen, size: d_size,
                   uns: d_unsigned, wdata: d_wdata};
    end else begin
      nxt_addr = i_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
      nxt_req  = '{wen: 1'b0, size: SZ_W,
                   uns: 1'b1, wdata: 32'd0};
    end
  end

  // Lane layout comes from the incoming request in IDLE, else the latched one
  always_comb begin
    cur_addr = (state_q == S_IDLE) ? nxt_addr : addr_q;
    cur_req  = (state_q == S_IDLE) ? nxt_req : req_q;
    lanes    = {4'b0000, size_mask(cur_req.size)} << cur_addr[1:0];
    steer    = {32'd0, cur_req.wdata} << {cur_addr[1:0], 3'b000};
    split    = |lanes[7:4];
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    last_d  = last_q;
    addr_d  = addr_q;
    req_d   = req_q;
    lo_d    = lo_q;
    maddr_d = maddr_q;
    be_d    = 4'b0000;
    mwen_d  = 1'b0;
    din_d   = din_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_i || gnt_d) begin
          state_d = S_BEAT1;
          port_d  = gnt_d ? P_D : P_I;
          last_d  = gnt_d ? P_D : P_I;
          addr_d  = nxt_addr;
          req_d   = nxt_req;
          maddr_d = nxt_addr[ADDR_W-1:2];
          be_d    = lanes[3:0];
          din_d   = steer[31:0];
          mwen_d  = nxt_req.wen;
        end
      end
      S_BEAT1: begin
        if (split) begin
          state_d = S_BEAT2;
          maddr_d = maddr_q + 1'b1;
          be_d    = lanes[7:4];
          din_d   = steer[63:32];
          mwen_d  = req_q.wen;
        end else begin
          state_d = S_RESP;
          i_ack_d = (port_q == P_I);
          d_ack_d = (port_q == P_D);
        end
      end
      S_BEAT2: begin
        lo_d    = mem_dout;
        state_d = S_RESP;
        i_ack_d = (port_q == P_I);
        d_ack_d = (port_q == P_D);
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= P_I;
      last_q  <= P_I;
      addr_q  <= '0;
      req_q   <= '0;
      lo_q    <= '0;
      maddr_q <= '0;
      be_q    <= '0;
      mwen_q  <= 1'b0;
      din_q   <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      lo_q    <= lo_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      mwen_q  <= mwen_d;
      din_q   <= din_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
    end
  end

  mem_load_align u_align (
    .hilo   ({mem_dout, split ? lo_q : mem_dout}),
    .off    (addr_q[1:0]),
    .size   (req_q.size),
    .uns    (req_q.uns),
    .result (ld_data)
  );

  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign i_rdata  = i_ack_q ? mem_dout : 32'd0;
  assign d_rdata  = (d_ack_q && !req_q.wen) ? ld_data : 32'd0;
  assign mem_addr = maddr_q;
  assign mem_be   = be_q;
  // A write strobe must never escape while reset is held
  assign mem_wen  = mwen_q & ~rst;
  assign mem_din  = din_q;

endmodule
